// File: rtl/rv32i_mc_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_mc_pkg
// Shared constants for the multi-cycle RV32I control unit: opcodes, ALU
// operation codes, write-back source codes, FSM state encodings and trap causes.
// -----------------------------------------------------------------------------
package rv32i_mc_pkg;

   // RV32I base opcodes (instr[6:0])
   localparam logic [6:0] OP_TYPE_R  = 7'b0110011;
   localparam logic [6:0] OP_TYPE_I  = 7'b0010011;
   localparam logic [6:0] OP_TYPE_L  = 7'b0000011;
   localparam logic [6:0] OP_TYPE_S  = 7'b0100011;
   localparam logic [6:0] OP_TYPE_B  = 7'b1100011;
   localparam logic [6:0] OP_TYPE_LU = 7'b0110111;
   localparam logic [6:0] OP_TYPE_AU = 7'b0010111;
   localparam logic [6:0] OP_TYPE_J  = 7'b1101111;
   localparam logic [6:0] OP_TYPE_JL = 7'b1100111;

   // ALU operation codes, {instr[30], funct3}
   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b1000;
   localparam logic [3:0] ALU_SLL  = 4'b0001;
   localparam logic [3:0] ALU_SLT  = 4'b0010;
   localparam logic [3:0] ALU_SLTU = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SRL  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b1101;
   localparam logic [3:0] ALU_OR   = 4'b0110;
   localparam logic [3:0] ALU_AND  = 4'b0111;

   // Register-file write-back source select
   localparam logic [2:0] RFWD_ALU   = 3'b000;
   localparam logic [2:0] RFWD_LOAD  = 3'b001;
   localparam logic [2:0] RFWD_LUI   = 3'b010;
   localparam logic [2:0] RFWD_AUIPC = 3'b011;
   localparam logic [2:0] RFWD_PC4   = 3'b100;

   // FSM state encodings (visible on stateDbg)
   typedef logic [2:0] state_e;
   localparam state_e ST_FETCH  = 3'd0;
   localparam state_e ST_DECODE = 3'd1;
   localparam state_e ST_EXE    = 3'd2;
   localparam state_e ST_MEM    = 3'd3;
   localparam state_e ST_WB     = 3'd4;
   localparam state_e ST_TRAP   = 3'd5;

   // Trap cause encodings
   typedef logic [1:0] trap_cause_e;
   localparam trap_cause_e TC_NONE    = 2'b00;
   localparam trap_cause_e TC_ILLEGAL = 2'b01;
   localparam trap_cause_e TC_DMEM_TO = 2'b10;

endpackage

// File: rtl/rv32i_main_decoder.sv
// -----------------------------------------------------------------------------
// rv32i_main_decoder
// Purely combinational static decode of the instruction register.
//   instrCode     in   32  instruction register contents
//   aluSrcMuxSel  out  1   1 = immediate operand
//   RFWDSrcMuxSel out  3   write-back source select
//   aluControl    out  4   ALU operation (unqualified by state)
//   regWrite      out  1   instruction writes rd in its EXE cycle
//   isLoad        out  1   load instruction
//   isStore       out  1   store instruction
//   isBranch      out  1   conditional branch
//   isJal         out  1   JAL
//   isJalr        out  1   JALR
//   illegal       out  1   opcode not in RV32I base set handled here
// -----------------------------------------------------------------------------
module rv32i_main_decoder
   import rv32i_mc_pkg::*;
(
   input  logic [31:0] instrCode,
   output logic        aluSrcMuxSel,
   output logic [2:0]  RFWDSrcMuxSel,
   output logic [3:0]  aluControl,
   output logic        regWrite,
   output logic        isLoad,
   output logic        isStore,
   output logic        isBranch,
   output logic        isJal,
   output logic        isJalr,
   output logic        illegal
);

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [3:0] ops;

   assign opcode = instrCode[6:0];
   assign funct3 = instrCode[14:12];
   assign ops    = {instrCode[30], funct3};

   // Register/immediate fields are consumed by the datapath, not here.
   logic unused_fields;
   assign unused_fields = ^{instrCode[31], instrCode[29:15], instrCode[11:7]};

   always_comb begin
      aluSrcMuxSel  = 1'b0;
      RFWDSrcMuxSel = RFWD_ALU;
      aluControl    = ops;
      regWrite      = 1'b0;
      isLoad        = 1'b0;
      isStore       = 1'b0;
      isBranch      = 1'b0;
      isJal         = 1'b0;
      isJalr        = 1'b0;
      illegal       = 1'b0;
      case (opcode)
         OP_TYPE_R: begin
            regWrite = 1'b1;
         end
         OP_TYPE_I: begin
            aluSrcMuxSel = 1'b1;
            regWrite     = 1'b1;
            // instr[30] is part of the immediate except for SRAI
            aluControl   = (ops == ALU_SRA) ? ops : {1'b0, funct3};
         end
         OP_TYPE_L: begin
            aluSrcMuxSel  = 1'b1;
            RFWDSrcMuxSel = RFWD_LOAD;
            aluControl    = ALU_ADD;
            isLoad        = 1'b1;
         end
         OP_TYPE_S: begin
            aluSrcMuxSel = 1'b1;
            aluControl   = ALU_ADD;
            isStore      = 1'b1;
         end
         OP_TYPE_B: begin
            isBranch = 1'b1;
         end
         OP_TYPE_LU: begin
            RFWDSrcMuxSel = RFWD_LUI;
            regWrite      = 1'b1;
         end
         OP_TYPE_AU: begin
            RFWDSrcMuxSel = RFWD_AUIPC;
            regWrite      = 1'b1;
         end
         OP_TYPE_J: begin
            RFWDSrcMuxSel = RFWD_PC4;
            regWrite      = 1'b1;
            isJal         = 1'b1;
         end
         OP_TYPE_JL: begin
            aluSrcMuxSel  = 1'b1;
            RFWDSrcMuxSel = RFWD_PC4;
            aluControl    = ALU_ADD;
            regWrite      = 1'b1;
            isJalr        = 1'b1;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/rv32i_mc_control_unit.sv
// -----------------------------------------------------------------------------
// rv32i_mc_control_unit
// Multi-cycle RV32I control FSM (FETCH/DECODE/EXE/MEM/WB/TRAP) with memory
// ready handshakes, data-memory timeout trap and retired-instruction counter.
//   clk, reset      clock and synchronous active-high reset
//   instrCode       instruction register contents
//   imemReady       fetched instruction valid this cycle
//   dmemReady       data access completes this cycle
//   stallReq        hold in FETCH (instruction boundary)
//   regFileWe       register write strobe
//   aluControl      ALU operation
//   aluSrcMuxSel    1 = immediate operand
//   dataWe, dataRe  store / load strobes
//   RFWDSrcMuxSel   write-back source select
//   branch/jal/jalr PC-select qualifiers (EXE only)
//   pcEn, irEn      PC and instruction register loads
//   trap, trapCause sticky trap flag and cause
//   instret         retired-instruction count
//   stateDbg        current state encoding
// -----------------------------------------------------------------------------
module rv32i_mc_control_unit
   import rv32i_mc_pkg::*;
#(
   parameter int unsigned CNT_W        = 32,
   parameter int unsigned DMEM_TIMEOUT = 16,
   parameter int unsigned IMEM_WAIT_EN = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      instrCode,
   input  logic             imemReady,
   input  logic             dmemReady,
   input  logic             stallReq,
   output logic             regFileWe,
   output logic [3:0]       aluControl,
   output logic             aluSrcMuxSel,
   output logic             dataWe,
   output logic             dataRe,
   output logic [2:0]       RFWDSrcMuxSel,
   output logic             branch,
   output logic             jal,
   output logic             jalr,
   output logic             pcEn,
   output logic             irEn,
   output logic             trap,
   output logic [1:0]       trapCause,
   output logic [CNT_W-1:0] instret,
   output logic [2:0]       stateDbg
);

   // Wide enough to hold DMEM_TIMEOUT; at least one bit when disabled.
   localparam int unsigned    TMO_W     = $clog2(DMEM_TIMEOUT + 2);
   localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(DMEM_TIMEOUT);
   localparam bit             TMO_EN    = (DMEM_TIMEOUT != 0);
   localparam bit             IMEM_WAIT = (IMEM_WAIT_EN != 0);

   state_e            state_q, state_d;
   trap_cause_e       cause_q, cause_d;
   logic              trap_q, trap_d;
   logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
   logic [CNT_W-1:0]  instret_q;

   logic [3:0] dec_alu;
   logic       reg_write, is_load, is_store, is_branch, is_jal, is_jalr, illegal;
   logic       fetch_ok, strobe_en;
   logic       in_fetch, in_exe, in_mem, in_wb;

   rv32i_main_decoder u_decoder (
      .instrCode     (instrCode),
      .aluSrcMuxSel  (aluSrcMuxSel),
      .RFWDSrcMuxSel (RFWDSrcMuxSel),
      .aluControl    (dec_alu),
      .regWrite      (reg_write),
      .isLoad        (is_load),
      .isStore       (is_store),
      .isBranch      (is_branch),
      .isJal         (is_jal),
      .isJalr        (is_jalr),
      .illegal       (illegal)
   );

   // stallReq has priority over a ready instruction memory.
   assign fetch_ok = (imemReady || !IMEM_WAIT) && !stallReq;
   assign tmo_inc  = tmo_q + TMO_W'(1);

   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      tmo_d   = '0;
      case (state_q)
         ST_FETCH: begin
            if (fetch_ok) state_d = ST_DECODE;
         end
         ST_DECODE: begin
            if (illegal) begin
               state_d = ST_TRAP;
               cause_d = TC_ILLEGAL;
            end else begin
               state_d = ST_EXE;
            end
         end
         ST_EXE: begin
            state_d = (is_load || is_store) ? ST_MEM : ST_FETCH;
         end
         ST_MEM: begin
            // A ready access completes even on the cycle the limit would hit.
            if (dmemReady) begin
               state_d = is_load ? ST_WB : ST_FETCH;
            end else if (TMO_EN && (tmo_inc == TMO_LIMIT)) begin
               state_d = ST_TRAP;
               cause_d = TC_DMEM_TO;
            end else begin
               state_d = ST_MEM;
               tmo_d   = TMO_EN ? tmo_inc : '0;
            end
         end
         ST_WB: begin
            state_d = ST_FETCH;
         end
         ST_TRAP: begin
            state_d = ST_TRAP;
         end
         default: begin
            state_d = ST_FETCH;
         end
      endcase
   end

   assign trap_d = trap_q || (state_d == ST_TRAP);

   assign strobe_en = !reset;
   assign in_fetch  = (state_q == ST_FETCH);
   assign in_exe    = (state_q == ST_EXE);
   assign in_mem    = (state_q == ST_MEM);
   assign in_wb     = (state_q == ST_WB);

   assign irEn      = strobe_en && in_fetch && fetch_ok;
   assign regFileWe = strobe_en && ((in_exe && reg_write) || (in_wb && is_load));
   assign branch    = strobe_en && in_exe && is_branch;
   assign jal       = strobe_en && in_exe && is_jal;
   assign jalr      = strobe_en && in_exe && is_jalr;
   assign dataWe    = strobe_en && in_mem && is_store;
   assign dataRe    = strobe_en && in_mem && is_load;
   assign pcEn      = strobe_en && ((in_exe && !is_load && !is_store) ||
                                    (in_mem && is_store && dmemReady) ||
                                    in_wb);

   assign aluControl = (state_q == ST_TRAP) ? ALU_ADD : dec_alu;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_FETCH;
         cause_q   <= TC_NONE;
         trap_q    <= 1'b0;
         tmo_q     <= '0;
         instret_q <= '0;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
         trap_q  <= trap_d;
         tmo_q   <= tmo_d;
         if (pcEn) instret_q <= instret_q + CNT_W'(1);
      end
   end

   assign trap      = trap_q;
   assign trapCause = cause_q;
   assign instret   = instret_q;
   assign stateDbg  = state_q;

endmodule

// File: tb/tb_rv32i_mc_control_unit.sv
module tb_rv32i_mc_control_unit;

   localparam int unsigned CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [31:0]      instrCode;
   logic             imemReady, dmemReady, stallReq;
   logic             regFileWe, aluSrcMuxSel, dataWe, dataRe;
   logic [3:0]       aluControl;
   logic [2:0]       RFWDSrcMuxSel;
   logic             branch, jal, jalr, pcEn, irEn, trap;
   logic [1:0]       trapCause;
   logic [CNT_W-1:0] instret;
   logic [2:0]       stateDbg;

   rv32i_mc_control_unit #(
      .CNT_W        (CNT_W),
      .DMEM_TIMEOUT (4),
      .IMEM_WAIT_EN (1)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .instrCode     (instrCode),
      .imemReady     (imemReady),
      .dmemReady     (dmemReady),
      .stallReq      (stallReq),
      .regFileWe     (regFileWe),
      .aluControl    (aluControl),
      .aluSrcMuxSel  (aluSrcMuxSel),
      .dataWe        (dataWe),
      .dataRe        (dataRe),
      .RFWDSrcMuxSel (RFWDSrcMuxSel),
      .branch        (branch),
      .jal           (jal),
      .jalr          (jalr),
      .pcEn          (pcEn),
      .irEn          (irEn),
      .trap          (trap),
      .trapCause     (trapCause),
      .instret       (instret),
      .stateDbg      (stateDbg)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   typedef struct {
      string       name;
      logic [31:0] ins;
      int          dwait;
      int          cyc;
      logic [3:0]  alu;
      logic        chk_src;
      logic        src;
      logic        chk_sel;
      logic [2:0]  sel;
      logic [7:0]  we_mask;
      logic [2:0]  bjj;
      int          n_re;
      int          n_wr;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input string name, input logic [31:0] ins, input int dwait,
                          input int cyc, input logic [3:0] alu, input logic chk_src,
                          input logic src, input logic chk_sel, input logic [2:0] sel,
                          input logic [7:0] we_mask, input logic [2:0] bjj,
                          input int n_re, input int n_wr);
      vec_t v;
      v.name = name; v.ins = ins; v.dwait = dwait; v.cyc = cyc; v.alu = alu;
      v.chk_src = chk_src; v.src = src; v.chk_sel = chk_sel; v.sel = sel;
      v.we_mask = we_mask; v.bjj = bjj; v.n_re = n_re; v.n_wr = n_wr;
      vecs.push_back(v);
   endtask

   // Aggregates collected by run_instr
   int         r_cyc, r_pc, r_ir, r_re, r_wr;
   logic [7:0] r_we_mask;
   logic [2:0] r_bjj, r_last, r_sel;
   logic [3:0] r_alu;
   logic       r_src;
   logic [CNT_W-1:0] model_instret;

   // Starts in FETCH at posedge+1; ends at posedge+1 after completion or trap entry.
   task automatic run_instr(input logic [31:0] ins, input int dwait, input int budget);
      int mem_seen;
      bit done;
      mem_seen = 0; done = 0;
      r_cyc = 0; r_pc = 0; r_ir = 0; r_re = 0; r_wr = 0;
      r_we_mask = '0; r_bjj = '0; r_last = '0; r_alu = '0; r_src = 1'b0; r_sel = '0;
      instrCode = ins;
      imemReady = 1'b1;
      dmemReady = (dwait == 0);
      while (!done && r_cyc < budget) begin
         @(negedge clk);
         r_cyc++;
         r_last = stateDbg;
         if (regFileWe) r_we_mask[stateDbg] = 1'b1;
         if (pcEn) r_pc++;
         if (irEn) r_ir++;
         if (dataRe) r_re++;
         if (dataWe) r_wr++;
         r_bjj = r_bjj | {branch, jal, jalr};
         if (stateDbg == 3'd1) begin
            r_alu = aluControl; r_src = aluSrcMuxSel; r_sel = RFWDSrcMuxSel;
         end
         if (stateDbg == 3'd3) mem_seen++;
         if (pcEn || stateDbg == 3'd5) done = 1;
         @(posedge clk); #1;
         imemReady = 1'b0;
         dmemReady = (mem_seen >= dwait);
      end
      dmemReady = 1'b0;
      if (!done) begin
         checks++;
         failures++;
         $display("FAIL run_budget got=no_completion expected=completion_within_%0d", budget);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      imemReady = 1'b0;
      dmemReady = 1'b0;
      stallReq = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      model_instret = '0;
   endtask

   initial begin
      reset = 1'b1; instrCode = 32'h0; imemReady = 1'b1; dmemReady = 1'b1; stallReq = 1'b0;
      model_instret = '0;

      //           name        instr         dw cyc alu  cs s  cl sel  we_mask      bjj  re wr
      add_vec("add",      32'h002081B3, 0, 3, 4'h0, 1, 0, 1, 3'd0, 8'b0000_0100, 3'b000, 0, 0);
      add_vec("sub",      32'h402081B3, 0, 3, 4'h8, 1, 0, 1, 3'd0, 8'b0000_0100, 3'b000, 0, 0);
      add_vec("addi",     32'h00500093, 0, 3, 4'h0, 1, 1, 1, 3'd0, 8'b0000_0100, 3'b000, 0, 0);
      add_vec("srai",     32'h4030D093, 0, 3, 4'hD, 1, 1, 1, 3'd0, 8'b0000_0100, 3'b000, 0, 0);
      add_vec("addi_b30", 32'h40000093, 0, 3, 4'h0, 1, 1, 1, 3'd0, 8'b0000_0100, 3'b000, 0, 0);
      add_vec("lw",       32'h0000A283, 0, 5, 4'h0, 1, 1, 1, 3'd1, 8'b0001_0000, 3'b000, 1, 0);
      add_vec("lw_wait3", 32'h0000A283, 3, 8, 4'h0, 1, 1, 1, 3'd1, 8'b0001_0000, 3'b000, 4, 0);
      add_vec("sw",       32'h0050A023, 0, 4, 4'h0, 1, 1, 0, 3'd0, 8'b0000_0000, 3'b000, 0, 1);
      add_vec("sw_wait3", 32'h0050A023, 3, 7, 4'h0, 1, 1, 0, 3'd0, 8'b0000_0000, 3'b000, 0, 4);
      add_vec("bne",      32'h00209463, 0, 3, 4'h1, 1, 0, 0, 3'd0, 8'b0000_0000, 3'b100, 0, 0);
      add_vec("lui",      32'h123450B7, 0, 3, 4'h5, 0, 0, 1, 3'd2, 8'b0000_0100, 3'b000, 0, 0);
      add_vec("auipc",    32'h00000097, 0, 3, 4'h0, 0, 0, 1, 3'd3, 8'b0000_0100, 3'b000, 0, 0);
      add_vec("jal",      32'h010000EF, 0, 3, 4'h0, 0, 0, 1, 3'd4, 8'b0000_0100, 3'b010, 0, 0);
      add_vec("jalr",     32'h00008067, 0, 3, 4'h0, 0, 0, 1, 3'd4, 8'b0000_0100, 3'b001, 0, 0);

      // Strobes forced low while reset is high, even with imemReady asserted
      @(posedge clk); #1;
      @(negedge clk);
      check("reset_irEn", irEn, 1'b0);
      @(posedge clk); #1;
      reset = 1'b0;
      imemReady = 1'b0;
      dmemReady = 1'b0;
      @(negedge clk);
      check("reset_state", stateDbg, 3'd0);
      check("reset_trap", {trap, trapCause}, 3'b000);
      check("reset_instret", instret, 4'd0);
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         run_instr(vecs[i].ins, vecs[i].dwait, 20);
         check({vecs[i].name, "_cycles"}, r_cyc, vecs[i].cyc);
         check({vecs[i].name, "_alu"}, r_alu, vecs[i].alu);
         if (vecs[i].chk_src) check({vecs[i].name, "_alusrc"}, r_src, vecs[i].src);
         if (vecs[i].chk_sel) check({vecs[i].name, "_rfwdsel"}, r_sel, vecs[i].sel);
         check({vecs[i].name, "_we_states"}, r_we_mask, vecs[i].we_mask);
         check({vecs[i].name, "_pcen_cnt"}, r_pc, 1);
         check({vecs[i].name, "_iren_cnt"}, r_ir, 1);
         check({vecs[i].name, "_bjj"}, r_bjj, vecs[i].bjj);
         check({vecs[i].name, "_re_cnt"}, r_re, vecs[i].n_re);
         check({vecs[i].name, "_we_cnt"}, r_wr, vecs[i].n_wr);
         model_instret = model_instret + 4'd1;
         check({vecs[i].name, "_instret"}, instret, model_instret);
      end

      // stallReq beats imemReady for 5 cycles, then fetch is accepted
      do_reset();
      instrCode = 32'h002081B3;
      stallReq = 1'b1;
      imemReady = 1'b1;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("stall_hold", {irEn, stateDbg}, 4'b0000);
         @(posedge clk); #1;
      end
      stallReq = 1'b0;
      @(negedge clk);
      check("stall_release_irEn", irEn, 1'b1);
      @(posedge clk); #1;
      imemReady = 1'b0;
      @(negedge clk);
      check("stall_release_decode", stateDbg, 3'd1);

      // Illegal opcode 7'h7F traps from DECODE; aluControl forced to ADD in TRAP
      do_reset();
      run_instr(32'h4000707F, 0, 10);
      check("illegal_cycles", r_cyc, 3);
      check("illegal_state", r_last, 3'd5);
      check("illegal_trap", {trap, trapCause}, 3'b101);
      check("illegal_alu", aluControl, 4'h0);
      imemReady = 1'b1;
      dmemReady = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("trap_strobes", {irEn, pcEn, regFileWe, dataWe, dataRe, branch, jal, jalr}, 8'h00);
         check("trap_absorb", stateDbg, 3'd5);
         @(posedge clk); #1;
      end
      do_reset();
      @(negedge clk);
      check("trap_reset", {stateDbg, trap, trapCause, instret}, 10'h000);
      @(posedge clk); #1;

      // Store never acknowledged: TRAP after 4 MEM cycles
      run_instr(32'h0050A023, 99, 16);
      check("tmo_cycles", r_cyc, 8);
      check("tmo_we_cnt", r_wr, 4);
      check("tmo_state", r_last, 3'd5);
      check("tmo_trap", {trap, trapCause}, 3'b110);
      check("tmo_instret", instret, 4'd0);
      dmemReady = 1'b1;
      @(negedge clk);
      check("tmo_dataWe_after", {dataWe, pcEn}, 2'b00);
      @(posedge clk); #1;

      // Reset in the middle of a store's MEM phase aborts it without pcEn
      do_reset();
      instrCode = 32'h0050A023;
      imemReady = 1'b1;
      @(posedge clk); #1;
      imemReady = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      reset = 1'b1;
      dmemReady = 1'b1;
      @(negedge clk);
      check("midmem_state", stateDbg, 3'd3);
      check("midmem_strobes", {dataWe, pcEn, dataRe, regFileWe}, 4'b0000);
      @(posedge clk); #1;
      reset = 1'b0;
      dmemReady = 1'b0;
      @(negedge clk);
      check("midmem_after", {stateDbg, instret}, 7'h00);
      @(posedge clk); #1;

      // 16 retirements wrap a 4-bit counter back to 0
      model_instret = '0;
      for (int k = 0; k < 16; k++) begin
         run_instr(32'h00500093, 0, 10);
         model_instret = model_instret + 4'd1;
         if (k == 14) check("wrap_15", instret, 4'd15);
      end
      check("wrap_0", instret, model_instret);
      check("wrap_0_abs", instret, 4'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
